wb_init_master: RTL

WB_INIT_MASTER -- requirements
Module: wb_init_master

---
 rtl/wb_init_master_if.sv | 75 +++++++
 rtl/wb_init_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_init_master_if.sv
// Local command/response channel and Wishbone classic master bus
// bundled for wb_init_master.
interface wb_init_master_if #(
    parameter int AW = 26,
    parameter int DW = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [DW/8-1:0] req_sel;
    logic [DW-1:0]   req_wdata;

    logic            rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            rsp_tmo;
    logic            stray_ack;

    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;

    modport master (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_sel,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output rsp_tmo,
        output stray_ack,
        output wb_cyc_o,
        output wb_stb_o,
        output wb_we_o,
        output wb_adr_o,
        output wb_sel_o,
        output wb_dat_o,
        input  wb_dat_i,
        input  wb_ack_i,
        input  wb_err_i
    );

    modport slave (
        output req_valid,
        output req_we,
        output req_addr,
        output req_sel,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  rsp_tmo,
        input  stray_ack,
        input  wb_cyc_o,
        input  wb_stb_o,
        input  wb_we_o,
        input  wb_adr_o,
        input  wb_sel_o,
        input  wb_dat_o,
        output wb_dat_i,
        output wb_ack_i,
        output wb_err_i
    );
endinterface

// File: rtl/wb_init_master.sv
// Single-transfer Wishbone classic master driven by a valid/ready command port.
// Optional bus-cycle timeout enabled by defining WB_TIMEOUT_EN.
module wb_init_master #(
    parameter int AW         = 26,
    parameter int DW         = 32,
    parameter int TMO_CYCLES = 255
) (
    input logic              wb_clk_i,
    input logic              wb_resetn,
    wb_init_master_if.master bus
);

    localparam int SW = DW / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            rdy_q;

    logic            cyc_q, cyc_d;
    logic            stb_q, stb_d;
    logic            we_q, we_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [DW-1:0]   dat_q, dat_d;

    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            stray_q, stray_d;

    logic            accept;
    logic            term;
    logic            term_err;

`ifdef WB_TIMEOUT_EN
    localparam int CW = $clog2(TMO_CYCLES + 1);

    logic [CW-1:0]   tmo_cnt_q;
    logic            tmo_hit;
    logic            rsp_tmo_q, rsp_tmo_d;

    assign tmo_hit = (tmo_cnt_q == CW'(TMO_CYCLES - 1));
`endif

    // Ready stays low in reset and for the first edge after it.
    assign accept = bus.req_valid && rdy_q && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_d       = dat_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        term        = 1'b0;
        term_err    = 1'b0;
`ifdef WB_TIMEOUT_EN
        rsp_tmo_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = bus.req_we;
                    adr_d   = bus.req_addr;
                    sel_d   = bus.req_sel;
                    dat_d   = bus.req_wdata;
                end
            end
            BUS: begin
                // Error has priority over ack when both arrive together.
                if (bus.wb_err_i) begin
                    term     = 1'b1;
                    term_err = 1'b1;
                end else if (bus.wb_ack_i) begin
                    term     = 1'b1;
                end
`ifdef WB_TIMEOUT_EN
                else if (tmo_hit) begin
                    term      = 1'b1;
                    term_err  = 1'b1;
                    rsp_tmo_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (term) begin
            state_d     = IDLE;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            we_d        = 1'b0;
            sel_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = term_err;
            if (!term_err && !we_q) begin
                rsp_rdata_d = bus.wb_dat_i;
            end
        end
    end

    // Any slave response while no cycle is open is recorded until reset.
    assign stray_d = stray_q ||
                     ((bus.wb_ack_i || bus.wb_err_i) && !cyc_q);

    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            stray_q     <= stray_d;
        end
    end

`ifdef WB_TIMEOUT_EN
    // Counter idles at zero, so every BUS entry starts a fresh count.
    always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
        if (!wb_resetn) begin
            tmo_cnt_q <= '0;
            rsp_tmo_q <= 1'b0;
        end else begin
            rsp_tmo_q <= rsp_tmo_d;
            if (state_q == IDLE || term) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CW'(1);
            end
        end
    end

    assign bus.rsp_tmo = rsp_tmo_q;
`else
    assign bus.rsp_tmo = 1'b0 & (TMO_CYCLES > 0);
`endif

    assign bus.req_ready = rdy_q && (state_q == IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.stray_ack = stray_q;
    assign bus.wb_cyc_o  = cyc_q;
    assign bus.wb_stb_o  = stb_q;
    assign bus.wb_we_o   = we_q;
    assign bus.wb_adr_o  = adr_q;
    assign bus.wb_sel_o  = sel_q;
    assign bus.wb_dat_o  = dat_q;

endmodule
